// File: rtl/db_pkg.sv
// Shared types and defaults for the push-button debounce bank.
package db_pkg;

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    // ~10.5 ms sample period at 100 MHz
    localparam int unsigned DB_CNT_W_DEFAULT = 20;

endpackage

// File: rtl/db_chan.sv
// One debounce channel: stability FSM stepped by the shared sample tick.
// DB_REPEAT_EN adds an auto-repeat counter that re-pulses tick while the button is held.
module db_chan import db_pkg::*; #(
`ifdef DB_REPEAT_EN
    parameter int unsigned REPEAT_DLY   = 50,
    parameter int unsigned REPEAT_PER   = 10,
`endif
    parameter int unsigned STABLE_TICKS = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s,
    input  logic sample_tick,
    output logic level,
    output logic tick
);

    localparam int unsigned SC_W = $clog2(STABLE_TICKS);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_TICKS - 1);

`ifdef DB_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_DLY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DLY - REPEAT_PER);

    logic [RPT_W-1:0] rpt_q;
`endif

    db_state_t       state_q;
    logic [SC_W-1:0] sc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ZERO;
            sc_q    <= '0;
            level   <= 1'b0;
            tick    <= 1'b0;
`ifdef DB_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            tick <= 1'b0;
`ifdef DB_REPEAT_EN
            // Held in WAIT0 so a short dip resumes the repeat cadence.
            if (state_q == ZERO || state_q == WAIT1) begin
                rpt_q <= '0;
            end
`endif
            unique case (state_q)
                ZERO: begin
                    if (s) begin
                        state_q <= WAIT1;
                        sc_q    <= '0;
                    end
                end
                WAIT1: begin
                    if (!s) begin
                        state_q <= ZERO;
                    end else if (sample_tick) begin
                        if (sc_q == SC_LAST) begin
                            state_q <= ONE;
                            level   <= 1'b1;
                            tick    <= 1'b1;
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                end
                ONE: begin
                    if (!s) begin
                        state_q <= WAIT0;
                        sc_q    <= '0;
                    end
`ifdef DB_REPEAT_EN
                    else if (sample_tick) begin
                        if (rpt_q == RPT_LAST) begin
                            rpt_q <= RPT_RELOAD;
                            tick  <= 1'b1;
                        end else begin
                            rpt_q <= rpt_q + 1'b1;
                        end
                    end
`endif
                end
                WAIT0: begin
                    if (s) begin
                        state_q <= ONE;
                    end else if (sample_tick) begin
                        if (sc_q == SC_LAST) begin
                            state_q <= ZERO;
                            level   <= 1'b0;
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ZERO;
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_bank.sv
// Multi-channel button conditioner: synchronisers, shared sample prescaler, N debounce channels.
// Define DB_REPEAT_EN to build per-channel auto-repeat on held buttons.
module btn_debounce_bank import db_pkg::*; #(
    parameter int unsigned N            = 4,
    parameter int unsigned CNT_W        = DB_CNT_W_DEFAULT,
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned REPEAT_DLY   = 50,
    parameter int unsigned REPEAT_PER   = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] btn,
    output logic [N-1:0] db_level,
    output logic [N-1:0] db_tick,
    output logic         sample_tick
);

    logic [N-1:0]     sync1_q;
    logic [N-1:0]     sync2_q;
    logic [CNT_W-1:0] pre_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pre_q       <= '0;
            sample_tick <= 1'b0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            pre_q       <= pre_q + 1'b1;
            sample_tick <= &pre_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        db_chan #(
`ifdef DB_REPEAT_EN
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_PER  (REPEAT_PER),
`endif
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .s          (sync2_q[i]),
            .sample_tick(sample_tick),
            .level      (db_level[i]),
            .tick       (db_tick[i])
        );
    end

endmodule
